speed_ramp_ctrl: RTL

SPEED_RAMP_CTRL -- requirements
Module: speed_ramp_ctrl

---
 rtl/speed_ramp_ctrl_pkg.sv | 21 ++
 rtl/speed_ramp_ctrl_period_timer.sv | 19 +
 rtl/speed_ramp_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/speed_ramp_ctrl_pkg.sv
// Shared definitions for the speed ramp controller and the PWM stage that consumes its speed code.
package speed_ramp_ctrl_pkg;

  localparam int unsigned SPEED_W = 3;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    STOP = 2'd2
  } state_t;

  // One code toward tgt, clamped to the legal speed range.
  function automatic logic [SPEED_W-1:0] step_toward(input logic [SPEED_W-1:0] cur,
                                                     input logic [SPEED_W-1:0] tgt);
    if (tgt > cur && cur != SPEED_MAX) return cur + SPEED_W'(1);
    if (tgt < cur && cur != '0) return cur - SPEED_W'(1);
    return cur;
  endfunction

endpackage

// File: rtl/speed_ramp_ctrl_period_timer.sv
// Free-running PWM-period counter; period_tick marks the last cycle of each period.
module period_timer #(
  parameter int unsigned PERIOD_BITS = 5
) (
  input  logic clock,
  input  logic reset,
  output logic period_tick
);

  logic [PERIOD_BITS-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else       count <= count + PERIOD_BITS'(1);
  end

  assign period_tick = &count;

endmodule

// File: rtl/speed_ramp_ctrl.sv
// Ramps the PWM speed code one step per DWELL_PERIODS periods toward a commanded target,
// with emergency stop and retargeting while ramping.
module speed_ramp_ctrl
  import speed_ramp_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_BITS   = 5,
  parameter int unsigned DWELL_PERIODS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SPEED_W-1:0] cmd_speed,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               estop,
  output logic [SPEED_W-1:0] speed,
  output logic               ramping,
  output logic               at_target,
  output logic               period_tick
);

  localparam logic [3:0] DWELL_LAST = 4'(DWELL_PERIODS - 1);

  state_t             state, state_nxt;
  logic [SPEED_W-1:0] target, target_nxt, speed_nxt;
  logic [3:0]         dwell, dwell_nxt;
  logic               at_target_nxt;
  logic               accept, step_due;

  period_timer #(.PERIOD_BITS(PERIOD_BITS)) u_period_timer (
    .clock      (clock),
    .reset      (reset),
    .period_tick(period_tick)
  );

  assign cmd_ready = !reset && !estop && (state != STOP);
  assign accept    = cmd_valid && cmd_ready;
  assign step_due  = (state == RAMP) && period_tick && (dwell == DWELL_LAST);
  assign ramping   = (state == RAMP);

  always_comb begin
    state_nxt     = state;
    speed_nxt     = speed;
    target_nxt    = target;
    dwell_nxt     = dwell;
    at_target_nxt = 1'b0;
    if (estop) begin
      state_nxt  = STOP;
      speed_nxt  = '0;
      target_nxt = '0;
      dwell_nxt  = '0;
    end else begin
      case (state)
        STOP: state_nxt = IDLE;
        IDLE: begin
          if (accept) begin
            target_nxt = cmd_speed;
            if (cmd_speed == speed) begin
              at_target_nxt = 1'b1;
            end else begin
              state_nxt = RAMP;
              dwell_nxt = '0;
            end
          end
        end
        RAMP: begin
          if (accept) target_nxt = cmd_speed;
          if (accept && cmd_speed == speed) begin
            state_nxt     = IDLE;
            at_target_nxt = 1'b1;
          end else begin
            // Step direction follows the (possibly just updated) target; arrival is judged
            // against the stepped speed so a same-edge retarget sees the new position.
            if (period_tick) dwell_nxt = step_due ? 4'd0 : dwell + 4'd1;
            if (step_due) speed_nxt = step_toward(speed, target_nxt);
            if (step_due && speed_nxt == target_nxt) begin
              state_nxt     = IDLE;
              at_target_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      speed     <= '0;
      target    <= '0;
      dwell     <= '0;
      at_target <= 1'b0;
    end else begin
      state     <= state_nxt;
      speed     <= speed_nxt;
      target    <= target_nxt;
      dwell     <= dwell_nxt;
      at_target <= at_target_nxt;
    end
  end

endmodule
